// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared encodings for the fetch-stage PC sequencing controller.
//   PCSRC_*  : pc mux select values driven on PCSrc_o
//   state_e  : controller FSM states
package pc_ctrl_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_IWAIT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   en       : increment this cycle
//   clr      : synchronous clear, wins over en
//   count_o  : current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC sequencing controller.
//   Inputs : clk, rst (async, active-high), Execute-stage branch/jump/jalr
//            decode, load-use hazard, instruction-memory ready.
//   Outputs: PC mux select, PC enable/reset, Decode stall/flush, Execute
//            flush, redirect and stall performance counters, sticky
//            instruction-fetch timeout flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RESET | PC held in reset; counts down the post-reset hold window
//   S_RUN   | normal fetch; PC advances or redirects every cycle
//   S_IWAIT | waiting on instruction memory; wait cycles are counted
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int IMEM_TIMEOUT      = 64,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 BranchE_i,
    input  logic                 BranchTakenE_i,
    input  logic                 JumpE_i,
    input  logic                 JalrE_i,
    input  logic                 LoadHazard_i,
    input  logic                 ImemReady_i,
    output logic [1:0]           PCSrc_o,
    output logic                 PCen_o,
    output logic                 PCrst_o,
    output logic                 StallD_o,
    output logic                 FlushD_o,
    output logic                 FlushE_o,
    output logic [CNT_WIDTH-1:0] RedirectCnt_o,
    output logic [CNT_WIDTH-1:0] StallCnt_o,
    output logic                 ImemTimeout_o
);

    localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic              redirect;
    logic              redirect_inc;
    logic              stall_inc;
    logic              wait_inc;
    logic              wait_clr;
    logic [WAIT_W-1:0] wait_cnt;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        timeout_d    = timeout_q;
        PCSrc_o      = PCSRC_PLUS4;
        PCen_o       = 1'b0;
        StallD_o     = 1'b0;
        FlushD_o     = 1'b1;
        FlushE_o     = 1'b1;
        redirect     = 1'b0;
        redirect_inc = 1'b0;
        stall_inc    = 1'b0;
        wait_inc     = 1'b0;
        wait_clr     = 1'b0;

        case (state_q)
            S_RESET: begin
                if (hold_q == 8'd0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end

            S_RUN, S_IWAIT: begin
                redirect = JalrE_i | JumpE_i | (BranchE_i & BranchTakenE_i);
                // jalr wins if decode ever raises jal and jalr together
                if (JalrE_i) begin
                    PCSrc_o = PCSRC_ALU;
                end else if (redirect) begin
                    PCSrc_o = PCSRC_TARGET;
                end

                if (redirect) begin
                    // redirect abandons any outstanding fetch
                    PCen_o       = 1'b1;
                    redirect_inc = 1'b1;
                    state_d      = S_RUN;
                end else if (LoadHazard_i) begin
                    StallD_o = 1'b1;
                    FlushD_o = 1'b0;
                end else if (!ImemReady_i) begin
                    FlushE_o = 1'b0;
                    if (state_q == S_RUN) begin
                        state_d  = S_IWAIT;
                        wait_clr = 1'b1;
                    end
                end else begin
                    PCen_o   = 1'b1;
                    FlushD_o = 1'b0;
                    FlushE_o = 1'b0;
                    state_d  = S_RUN;
                end

                stall_inc = ~PCen_o;
                wait_inc  = (state_q == S_IWAIT) && !ImemReady_i;
                // flag sets on the edge where the wait count reaches the limit
                if (wait_inc && (wait_cnt == WAIT_W'(IMEM_TIMEOUT - 1))) begin
                    timeout_d = 1'b1;
                end
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET;
            hold_q    <= 8'(RESET_HOLD_CYCLES - 1);
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign PCrst_o       = (state_q == S_RESET);
    assign ImemTimeout_o = timeout_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (redirect_inc),
        .clr     (1'b0),
        .count_o (RedirectCnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (stall_inc),
        .clr     (1'b0),
        .count_o (StallCnt_o)
    );

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (wait_inc),
        .clr     (wait_clr),
        .count_o (wait_cnt)
    );

endmodule
